// File: rtl/puf_response_stabilizer_if.sv
// rtl/puf_response_stabilizer_if.sv - request, PUF-core and result signals of the PUF response stabilizer
//
// Purpose: bundles every non-clock/reset signal of puf_response_stabilizer.
//   master modport : requester + PUF core side (drives start/seed/raw results)
//   slave modport  : the stabilizer itself
// Signals:
//   start          request, sampled only while the stabilizer is idle
//   challenge_seed 16-bit challenge latched on an accepted start
//   puf_challenge  challenge driven to the PUF core for the whole run
//   puf_eval       one-cycle evaluate strobe to the PUF core
//   puf_raw_valid  PUF core raw result valid
//   puf_raw        16-bit raw PUF response
//   puf_response   majority-voted response
//   puf_ready      one-cycle result-valid pulse
//   busy           high whenever a run is in progress
//   unstable_mask  per-bit marginal flag
//   stable_err     OR of unstable_mask
//   timeout        last run aborted because the PUF core never answered

interface puf_response_stabilizer_if;
  logic        start;
  logic [15:0] challenge_seed;
  logic [15:0] puf_challenge;
  logic        puf_eval;
  logic        puf_raw_valid;
  logic [15:0] puf_raw;
  logic [15:0] puf_response;
  logic        puf_ready;
  logic        busy;
  logic [15:0] unstable_mask;
  logic        stable_err;
  logic        timeout;

  modport master (
    output start, challenge_seed, puf_raw_valid, puf_raw,
    input  puf_challenge, puf_eval, puf_response, puf_ready, busy,
           unstable_mask, stable_err, timeout
  );

  modport slave (
    input  start, challenge_seed, puf_raw_valid, puf_raw,
    output puf_challenge, puf_eval, puf_response, puf_ready, busy,
           unstable_mask, stable_err, timeout
  );
endinterface

// File: rtl/puf_response_stabilizer.sv
// rtl/puf_response_stabilizer.sv - repeats one PUF challenge and majority-votes a stable 16-bit response
//
// Purpose: on start, evaluates the PUF NUM_SAMPLES times with the same
// challenge, counts ones per response bit, votes each bit, flags bits whose
// minority count exceeds FLIP_TOL, and aborts with a timeout if the PUF core
// stays silent for TIMEOUT_CYC cycles after an evaluate strobe.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    puf_response_stabilizer_if.slave (request, PUF core, results)

module puf_response_stabilizer #(
  parameter int NUM_SAMPLES = 7,
  parameter int CNT_W       = 5,
  parameter int FLIP_TOL    = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                             clk,
  input  logic                             rst_n,
  puf_response_stabilizer_if.slave         bus
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] N_C    = CNT_W'(NUM_SAMPLES);
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(NUM_SAMPLES / 2);
  localparam logic [CNT_W-1:0] TOL_C  = CNT_W'(FLIP_TOL);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NUM_SAMPLES - 1);
  // Timer value whose increment reaches TIMEOUT_CYC-1, i.e. the last WAIT cycle.
  localparam logic [TIMER_W-1:0] TMO_C = TIMER_W'(TIMEOUT_CYC - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_VOTE,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        challenge_q, challenge_d;
  logic [CNT_W-1:0]   ones_q [16];
  logic [CNT_W-1:0]   ones_d [16];
  logic [CNT_W-1:0]   sample_q, sample_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [15:0]        response_q, response_d;
  logic [15:0]        mask_q, mask_d;
  logic               err_q, err_d;
  logic               timeout_q, timeout_d;

  // A bit is marginal when the losing value appeared more than FLIP_TOL times.
  function automatic logic is_unstable(input logic [CNT_W-1:0] ones);
    logic [CNT_W-1:0] minority;
    minority = (ones > HALF_C) ? (N_C - ones) : ones;
    return minority > TOL_C;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      challenge_q <= '0;
      for (int i = 0; i < 16; i++) ones_q[i] <= '0;
      sample_q    <= '0;
      timer_q     <= '0;
      response_q  <= '0;
      mask_q      <= '0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      challenge_q <= challenge_d;
      for (int i = 0; i < 16; i++) ones_q[i] <= ones_d[i];
      sample_q    <= sample_d;
      timer_q     <= timer_d;
      response_q  <= response_d;
      mask_q      <= mask_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    challenge_d = challenge_q;
    for (int i = 0; i < 16; i++) ones_d[i] = ones_q[i];
    sample_d    = sample_q;
    timer_d     = timer_q;
    response_d  = response_q;
    mask_d      = mask_q;
    err_d       = err_q;
    timeout_d   = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          challenge_d = bus.challenge_seed;
          for (int i = 0; i < 16; i++) ones_d[i] = '0;
          sample_d  = '0;
          timeout_d = 1'b0;
          err_d     = 1'b0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.puf_raw_valid) begin
          for (int i = 0; i < 16; i++) ones_d[i] = ones_q[i] + CNT_W'(bus.puf_raw[i]);
          sample_d = sample_q + CNT_W'(1);
          state_d  = (sample_q == LAST_C) ? S_VOTE : S_ISSUE;
        end else if (timer_q == TMO_C) begin
          timeout_d  = 1'b1;
          response_d = 16'h0000;
          mask_d     = 16'hFFFF;
          err_d      = 1'b1;
          state_d    = S_DONE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_VOTE: begin
        for (int i = 0; i < 16; i++) begin
          response_d[i] = ones_q[i] > HALF_C;
          mask_d[i]     = is_unstable(ones_q[i]);
        end
        err_d   = |mask_d;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes decode straight from the state register so reset clears them at once.
  assign bus.puf_eval      = (state_q == S_ISSUE);
  assign bus.puf_ready     = (state_q == S_DONE);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.puf_challenge = challenge_q;
  assign bus.puf_response  = response_q;
  assign bus.unstable_mask = mask_q;
  assign bus.stable_err    = err_q;
  assign bus.timeout       = timeout_q;

endmodule

// File: tb/tb_puf_response_stabilizer.sv
// tb/tb_puf_response_stabilizer.sv - scoreboard bench for puf_response_stabilizer

module tb_puf_response_stabilizer;

  localparam int N   = 7;
  localparam int TOL = 1;
  localparam int TO  = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  puf_response_stabilizer_if bus ();

  puf_response_stabilizer #(
    .NUM_SAMPLES(N),
    .CNT_W      (5),
    .FLIP_TOL   (TOL),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [15:0] resp;
    logic [15:0] mask;
    logic        err;
    logic        tmo;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          ready_cnt = 0;
  logic [15:0] raw_tab[N];
  int          lat_tab[N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: per-bit popcount across the sample table, then vote and margin test.
  function automatic exp_t model();
    exp_t e;
    int ones;
    e = '0;
    for (int b = 0; b < 16; b++) begin
      ones = 0;
      for (int s = 0; s < N; s++) ones += int'(raw_tab[s][b]);
      e.resp[b] = (2 * ones > N);
      e.mask[b] = (((ones < N - ones) ? ones : N - ones) > TOL);
    end
    e.err = |e.mask;
    e.tmo = 1'b0;
    return e;
  endfunction

  // Monitor: every puf_ready pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.puf_ready) begin
      ready_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("puf_response", {16'h0, bus.puf_response}, {16'h0, e.resp});
        check("unstable_mask", {16'h0, bus.unstable_mask}, {16'h0, e.mask});
        check("stable_err", {31'h0, bus.stable_err}, {31'h0, e.err});
        check("timeout", {31'h0, bus.timeout}, {31'h0, e.tmo});
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_response"}, {16'h0, bus.puf_response}, 32'h0);
    check({tag, "_mask"}, {16'h0, bus.unstable_mask}, 32'h0);
    check({tag, "_challenge"}, {16'h0, bus.puf_challenge}, 32'h0);
    check({tag, "_flags"}, {27'h0, bus.stable_err, bus.timeout, bus.busy, bus.puf_ready, bus.puf_eval}, 32'h0);
  endtask

  // Acts as requester and PUF core for one run. stall_at/abort_at = sample index
  // (0-based) whose eval gets no answer / gets reset during its WAIT; -1 = none.
  task automatic run(input logic [15:0] seed, input int stall_at, input int abort_at,
                     input bit hold_start, input bit spurious);
    exp_t e;
    int   rc0, t0, evals, e_cyc, r_cyc, exp_cyc;
    bit   got;
    rc0   = ready_cnt;
    evals = 0;
    e_cyc = 0;
    if (stall_at >= 0) begin
      e = '0; e.mask = 16'hFFFF; e.err = 1'b1; e.tmo = 1'b1;
    end else begin
      e = model();
    end
    if (abort_at < 0) exp_q.push_back(e);

    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.challenge_seed = seed;
    t0 = cyc;
    if (spurious) begin bus.puf_raw_valid = 1'b1; bus.puf_raw = 16'hFFFF; end
    @(posedge clk); #1;
    bus.puf_raw_valid = 1'b0;
    if (!hold_start) bus.start = 1'b0;
    bus.challenge_seed = ~seed;

    for (int k = 0; k < N; k++) begin
      got = 1'b0;
      for (int w = 0; w < 50 && !got; w++) begin
        @(negedge clk);
        if (bus.puf_eval) got = 1'b1;
      end
      if (!got) begin
        check("eval_wait_expired", 32'd0, 32'd1);
        break;
      end
      evals++;
      e_cyc = cyc;
      if (spurious) begin bus.puf_raw_valid = 1'b1; bus.puf_raw = 16'hFFFF; end
      if (k == abort_at) begin
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.start = 1'b0;
        repeat (30) @(posedge clk);
        check("ready_after_abort", ready_cnt, rc0);
        return;
      end
      if (k == stall_at) break;
      repeat (lat_tab[k]) begin @(posedge clk); #1; bus.puf_raw_valid = 1'b0; end
      bus.puf_raw_valid = 1'b1;
      bus.puf_raw = raw_tab[k];
      @(posedge clk); #1;
      bus.puf_raw_valid = 1'b0;
    end

    got = 1'b0;
    r_cyc = 0;
    for (int w = 0; w < 400 && !got; w++) begin
      @(negedge clk);
      if (bus.puf_ready) begin
        got = 1'b1;
        r_cyc = cyc;
        bus.start = 1'b0;
      end
    end
    if (!got) begin
      check("ready_wait_expired", 32'd0, 32'd1);
      bus.start = 1'b0;
      return;
    end
    if (stall_at >= 0) begin
      exp_cyc = e_cyc + TO;
      check("eval_count", evals, stall_at + 1);
    end else begin
      exp_cyc = t0 + 2;
      for (int k = 0; k < N; k++) exp_cyc += lat_tab[k] + 1;
      check("eval_count", evals, N);
    end
    check("ready_cycle", r_cyc, exp_cyc);
    check("challenge_held", {16'h0, bus.puf_challenge}, {16'h0, seed});
    repeat (3) @(negedge clk);
    check("idle_after_done", {30'h0, bus.busy, bus.puf_eval}, 32'h0);
    check("single_ready", ready_cnt, rc0 + 1);
  endtask

  task automatic fill(input logic [15:0] raw, input int lat);
    for (int s = 0; s < N; s++) begin raw_tab[s] = raw; lat_tab[s] = lat; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] base;
    bus.start = 1'b0;
    bus.challenge_seed = 16'h0;
    bus.puf_raw_valid = 1'b0;
    bus.puf_raw = 16'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Constant response, minimum latency.
    fill(16'hA5C3, 1);
    run(16'h1111, -1, -1, 1'b0, 1'b0);

    // Marginal bits: bit0 in 1/7, bit3 in 3/7, bit9 in 6/7.
    fill(16'h0000, 1);
    for (int s = 0; s < N; s++) begin
      raw_tab[s][0] = (s < 1);
      raw_tab[s][3] = (s < 3);
      raw_tab[s][9] = (s < 6);
    end
    run(16'h2222, -1, -1, 1'b0, 1'b0);

    // PUF goes silent after the third eval, then a normal run.
    fill(16'hBEEF, 1);
    run(16'h3333, 2, -1, 1'b0, 1'b0);
    fill(16'h0F0F, 1);
    run(16'h4444, -1, -1, 1'b0, 1'b0);

    // start held high and spurious valid in IDLE/ISSUE.
    fill(16'hA5C3, 1);
    run(16'h5555, -1, -1, 1'b1, 1'b1);

    // Reset during WAIT of the fourth sample, then a fresh run.
    fill(16'h7777, 1);
    run(16'h6666, -1, 3, 1'b0, 1'b0);
    fill(16'h1234, 1);
    run(16'h1234, -1, -1, 1'b0, 1'b0);

    // Random PUF latency.
    fill(16'h5A5A, 1);
    for (int s = 0; s < N; s++) lat_tab[s] = $urandom_range(20, 1);
    run(16'h8888, -1, -1, 1'b0, 1'b0);

    // Random noisy responses with random latency.
    for (int r = 0; r < 10; r++) begin
      base = 16'($urandom);
      for (int s = 0; s < N; s++) begin
        raw_tab[s] = base ^ 16'($urandom & $urandom & $urandom);
        lat_tab[s] = $urandom_range(4, 1);
      end
      run(16'($urandom), -1, -1, 1'b0, 1'b0);
    end

    repeat (5) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
